// File: rtl/rr_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types, default sizing constants and helpers for rr_req_arbiter.
//   arb_state_t    : arbiter FSM state encoding (IDLE / BUSY)
//   onehot_to_idx  : binary index of a one-hot vector (up to ARB_MAX_WIDTH bits)
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_DEFAULT_WIDTH   = 12;
    localparam int ARB_DEFAULT_TIMEOUT = 16;

    // Widest requester vector the index helper accepts. Callers zero-extend
    // their one-hot vector up to this width before calling.
    localparam int ARB_MAX_WIDTH = 256;

    // OR-ing the indices of all set bits yields the index directly when the
    // input is one-hot, and 0 for an all-zero input. This avoids a priority
    // chain in synthesis.
    function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_WIDTH-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_WIDTH; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_req_arbiter_lsb_onehot_finder.sv
// -----------------------------------------------------------------------------
// lsb_onehot_finder
// Combinational lowest-set-bit detector.
//   vec_i    [WIDTH] : input vector
//   onehot_o [WIDTH] : one-hot of the lowest set bit of vec_i, 0 when vec_i==0
// -----------------------------------------------------------------------------
module lsb_onehot_finder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [WIDTH-1:0] onehot_o
);

    // Two's complement isolates the lowest set bit: x & -x.
    assign onehot_o = vec_i & (~vec_i + WIDTH'(1));

endmodule

// File: rtl/rr_req_arbiter.sv
// -----------------------------------------------------------------------------
// rr_req_arbiter
// Round-robin arbiter sharing one downstream resource among WIDTH requesters.
// A registered one-hot grant is held for a whole burst and released when the
// resource accepts a beat flagged last; priority then rotates past the grantee.
//
// Ports:
//   clk_i        : clock
//   srst_i       : synchronous active-high reset
//   req_i        [WIDTH]          : request vector, bit n = requester n
//   ready_i      : resource accepts current beat
//   last_i       : current beat is the final beat of the burst
//   gnt_o        [WIDTH]          : one-hot grant, 0 when idle
//   gnt_valid_o  : a grant is active
//   gnt_id_o     [$clog2(WIDTH)]  : index of granted requester, 0 when idle
//   timeout_o    : one-cycle pulse on forced release
//
// Build option:
//   ARB_TIMEOUT_EN : when defined, a grant stalled (ready_i=0) for
//                    TIMEOUT_CYCLES consecutive cycles is revoked and timeout_o
//                    pulses for one cycle. When undefined, timeout_o is 0 and a
//                    grant may be held indefinitely.
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant active; any request is granted at the next edge
// BUSY  | grant held until last beat accepted (or stall timeout)
// -----------------------------------------------------------------------------
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH          = ARB_DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         req_i,
    input  logic                     ready_i,
    input  logic                     last_i,
    output logic [WIDTH-1:0]         gnt_o,
    output logic                     gnt_valid_o,
    output logic [$clog2(WIDTH)-1:0] gnt_id_o,
    output logic                     timeout_o
);

    localparam int IDW = $clog2(WIDTH);

    arb_state_t       state_q, state_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic [WIDTH-1:0] above_ptr;
    logic [WIDTH-1:0] req_masked;
    logic [WIDTH-1:0] lsb_masked;
    logic [WIDTH-1:0] lsb_all;
    logic [WIDTH-1:0] win_oh;
    logic [IDW-1:0]   win_idx;
    logic             any_req;
    logic             release_gnt;
    logic             issue_gnt;

    // ---------------------------------------------------------------------
    // Arbitration: requesters strictly above the last grantee win first;
    // if none, wrap around to the lowest requester overall. The grantee
    // itself is only reached through the wrap, i.e. at lowest priority.
    // ---------------------------------------------------------------------
    always_comb begin
        above_ptr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            above_ptr[i] = (i > int'(ptr_q));
        end
    end

    assign req_masked = req_i & above_ptr;
    assign any_req    = |req_i;

    lsb_onehot_finder #(.WIDTH(WIDTH)) u_lsb_masked (
        .vec_i    (req_masked),
        .onehot_o (lsb_masked)
    );

    lsb_onehot_finder #(.WIDTH(WIDTH)) u_lsb_all (
        .vec_i    (req_i),
        .onehot_o (lsb_all)
    );

    assign win_oh  = (|req_masked) ? lsb_masked : lsb_all;
    assign win_idx = IDW'(onehot_to_idx(ARB_MAX_WIDTH'(win_oh)));

    // ---------------------------------------------------------------------
    // Stall timeout (optional)
    // ---------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] stall_q, stall_d;
    logic             timeout_q, timeout_d;
`endif

    // ---------------------------------------------------------------------
    // FSM next-state / outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        release_gnt = 1'b0;
        issue_gnt   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        stall_d     = stall_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                issue_gnt = any_req;
            end

            BUSY: begin
                if (ready_i) begin
                    release_gnt = last_i;
`ifdef ARB_TIMEOUT_EN
                    stall_d     = '0;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else if (stall_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Forced release behaves exactly like an accepted last beat.
                    release_gnt = 1'b1;
                    timeout_d   = 1'b1;
                    stall_d     = '0;
                end else begin
                    stall_d = stall_q + CNT_W'(1);
                end
`endif

                if (release_gnt) begin
                    if (any_req) begin
                        issue_gnt = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase

        // ptr moves only when a grant is actually issued.
        if (issue_gnt) begin
            state_d  = BUSY;
            gnt_d    = win_oh;
            gnt_id_d = win_idx;
            ptr_d    = win_idx;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= IDW'(WIDTH - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = (state_q == BUSY);

endmodule

// File: tb/tb_rr_req_arbiter.sv
module tb_rr_req_arbiter;

    localparam int W  = 4;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         srst;
    logic [W-1:0] req;
    logic         ready;
    logic         last;
    logic [W-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state: who holds the grant, where priority starts,
    // how long the current holder has stalled, and whether a timeout fired.
    int m_busy  = 0;
    int m_gid   = 0;
    int m_ptr   = W - 1;
    int m_stall = 0;
    int m_to    = 0;

    rr_req_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .req_i       (req),
        .ready_i     (ready),
        .last_i      (last),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    // Walk the ring starting just after p; p itself is visited last.
    function automatic int rr_pick(input logic [W-1:0] r, input int p);
        for (int k = 1; k <= W; k++) begin
            if (r[(p + k) % W]) return (p + k) % W;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] exp_gnt();
        return (m_busy != 0) ? (4'b0001 << m_gid) : 4'b0000;
    endfunction

    function automatic logic [1:0] exp_id();
        return (m_busy != 0) ? 2'(m_gid) : 2'd0;
    endfunction

    // Advance one clock, update the model with the inputs seen at that edge,
    // and return 1 time unit after the edge.
    task automatic tick();
        int w;
        int rel;
        int to_n;
        @(posedge clk);
        if (srst) begin
            m_busy = 0; m_gid = 0; m_ptr = W - 1; m_stall = 0; m_to = 0;
        end else begin
            rel  = 0;
            to_n = 0;
            if (m_busy == 0) begin
                w = rr_pick(req, m_ptr);
                if (w >= 0) begin m_busy = 1; m_gid = w; m_ptr = w; end
            end else begin
                if (ready) begin
                    m_stall = 0;
                    if (last) rel = 1;
                end else if (TO_EN) begin
                    if (m_stall == TO - 1) begin rel = 1; to_n = 1; m_stall = 0; end
                    else m_stall++;
                end
                if (rel != 0) begin
                    w = rr_pick(req, m_ptr);
                    if (w >= 0) begin m_gid = w; m_ptr = w; end
                    else begin m_busy = 0; m_gid = 0; end
                end
            end
            m_to = to_n;
        end
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1; req = '0; ready = 1'b0; last = 1'b0;
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; req = '0; ready = 1'b0; last = 1'b0;
        tick(); tick();
        srst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got v=%b g=%b id=%0d to=%b exp v=0 g=0000 id=0 to=0",
                         i, gnt_valid, gnt, gnt_id, timeout);
            end
        end
    endtask

    task automatic test_rotation();
        logic [W-1:0] seq [8];
        seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        req = 4'b1011; ready = 1'b1; last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (gnt !== seq[i] || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation step %0d got g=%b v=%b exp g=%b v=1", i, gnt, gnt_valid, seq[i]);
            end
        end
    endtask

    task automatic test_burst_hold();
        logic rdy_pat [4];
        logic lst_pat [4];
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        lst_pat = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        req = 4'b0110; ready = 1'b0; last = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            ready = rdy_pat[i];
            last  = lst_pat[i];
            checks++;
            if (gnt !== 4'b0010) begin
                errors++;
                $display("FAIL burst_hold beat %0d got %b exp 0010", i, gnt);
            end
            tick();
        end
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL burst_next got %b exp 0100", gnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; ready = 1'b1; last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL single cyc %0d got g=%b id=%0d v=%b exp g=0100 id=2 v=1",
                         i, gnt, gnt_id, gnt_valid);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL single_idle got v=%b g=%b id=%0d exp v=0 g=0000 id=0", gnt_valid, gnt, gnt_id);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010; ready = 1'b0; last = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mid_grant got %b exp 0010", gnt);
        end
        tick();
        srst = 1'b1; req = 4'b1001;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b g=%b id=%0d to=%b exp all 0", gnt_valid, gnt, gnt_id, timeout);
        end
        srst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_regrant got g=%b id=%0d exp g=0001 id=0", gnt, gnt_id);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0011; ready = 1'b0; last = 1'b0;
        tick();
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            checks++;
            if (timeout !== 1'b0 || gnt !== 4'b0001) begin
                errors++;
                $display("FAIL timeout_wait stall %0d got to=%b g=%b exp to=0 g=0001", i + 1, timeout, gnt);
            end
        end
        tick();
        checks++;
        if (timeout !== 1'b1 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_fire got to=%b g=%b exp to=1 g=0010", timeout, gnt);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse got to=%b exp 0", timeout);
        end
    endtask
`endif

    task automatic test_random();
        int ready_pct;
        do_reset();
        ready_pct = 80;
        for (int i = 0; i < 1200; i++) begin
            if (i % 60 == 0) ready_pct = (($urandom_range(0, 2) == 0) ? 5 : 75);
            req   = W'($urandom);
            ready = ($urandom_range(0, 99) < ready_pct);
            last  = ($urandom_range(0, 2) == 0);
            srst  = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if (gnt !== exp_gnt() || gnt_id !== exp_id() || gnt_valid !== (m_busy != 0)
                || timeout !== (m_to != 0)) begin
                errors++;
                $display("FAIL random cyc %0d got g=%b id=%0d v=%b to=%b exp g=%b id=%0d v=%0d to=%0d",
                         i, gnt, gnt_id, gnt_valid, timeout, exp_gnt(), exp_id(), m_busy, m_to);
            end
        end
        srst = 1'b0;
    endtask

    initial begin
        srst = 1'b1; req = '0; ready = 1'b0; last = 1'b0;
        test_reset();
        test_rotation();
        test_burst_hold();
        test_single();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
